// File: rtl/conv_pkg.sv
// Shared types and width helpers for the pipelined KxK convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_DIV   = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_RAW   = 2'd2
  } mode_e;

  typedef enum logic {
    NS_IDLE = 1'b0,
    NS_DIV  = 1'b1
  } norm_state_e;

  // Pixel is zero-extended by one bit and then treated as signed, hence +1.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int k);
    return prod_w(data_w, coef_w) + $clog2(k * k);
  endfunction

  function automatic int csum_w(input int coef_w, input int k);
    return coef_w + $clog2(k * k);
  endfunction

  function automatic int sh_w(input int data_w, input int coef_w, input int k);
    return $clog2(acc_w(data_w, coef_w, k));
  endfunction

endpackage

// File: rtl/conv_pipe_engine_if.sv
// Window/filter input stream, pixel output stream and normaliser debug view.
interface conv_pipe_engine_if
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3
);
  localparam int N    = K * K;
  localparam int SH_W = sh_w(DATA_W, COEF_W, K);

  // Both streams: a beat transfers on the rising edge where valid && ready;
  // valid and its payload stay stable until then, and ready may depend on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   window;
  logic [N*COEF_W-1:0]   filter;
  logic [1:0]            mode;
  logic [SH_W-1:0]       shift_amt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_pixel;
  norm_state_e           norm_state;
  logic [SH_W-1:0]       div_cnt;

  modport master (
    output in_valid, window, filter, mode, shift_amt, out_ready,
    input  in_ready, out_valid, out_pixel, norm_state, div_cnt
  );

  modport slave (
    input  in_valid, window, filter, mode, shift_amt, out_ready,
    output in_ready, out_valid, out_pixel, norm_state, div_cnt
  );
endinterface

// File: rtl/conv_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, W cycles per divide.
module conv_seq_divider #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  rem, quo, dvs, rem_next;
  logic [W:0]    partial, trial;
  logic [CW-1:0] count;

  // quotient is the post-iteration value, so it is final in the cycle done is high.
  always_comb begin
    partial  = {rem, quo[W-1]};
    trial    = partial - {1'b0, dvs};
    rem_next = trial[W] ? partial[W-1:0] : trial[W-1:0];
    quotient = {quo[W-2:0], ~trial[W]};
  end

  assign done = busy && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= CW'(W - 1);
    end else if (busy) begin
      rem   <= rem_next;
      quo   <= quotient;
      count <= count - 1'b1;
      if (count == '0) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/conv_pipe_engine.sv
// KxK convolution: S1 products, S2 adder trees, normaliser FSM, clamp, output register.
module conv_pipe_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3
) (
  input logic               clk,
  input logic               rst,
  conv_pipe_engine_if.slave bus
);
  localparam int N      = K * K;
  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, K);
  localparam int CSUM_W = csum_w(COEF_W, K);
  localparam int SH_W   = sh_w(DATA_W, COEF_W, K);
  localparam logic signed [ACC_W:0] PIX_MAX  = (ACC_W+1)'((1 << DATA_W) - 1);
  localparam logic [SH_W-1:0]       CNT_LOAD = SH_W'(ACC_W - 1);

  logic                     s1_valid, s2_valid, s1_advance, s2_advance, s2_consume;
  logic signed [PROD_W-1:0] prod_in [N];
  logic signed [PROD_W-1:0] s1_prod [N];
  logic signed [COEF_W-1:0] s1_coef [N];
  logic [1:0]               s1_mode, s2_mode;
  logic [SH_W-1:0]          s1_shift, s2_shift;
  logic signed [ACC_W-1:0]  acc_sum, s2_acc;
  logic signed [CSUM_W-1:0] csum_sum, s2_csum;

  norm_state_e              state, state_next;
  logic [SH_W-1:0]          cnt, cnt_next;
  logic                     div_start, div_busy, div_done, out_write, out_free, want_div;
  logic [CSUM_W-1:0]        csum_mag;
  logic [ACC_W-1:0]         abs_acc, abs_csum, quotient;
  logic signed [ACC_W:0]    direct_r, div_r, norm_r;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_pixel_q;

  function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W:0] r);
    if (r < 0) return '0;
    if (r > PIX_MAX) return '1;
    return r[DATA_W-1:0];
  endfunction

  assign s2_advance   = !s2_valid || s2_consume;
  assign s1_advance   = !s1_valid || s2_advance;
  assign bus.in_ready = s1_advance;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_in[i] = $signed({{(COEF_W+1){1'b0}}, bus.window[(N-i)*DATA_W-1 -: DATA_W]}) *
                   $signed({{(DATA_W+1){bus.filter[(N-i)*COEF_W-1]}},
                            bus.filter[(N-i)*COEF_W-1 -: COEF_W]});
    end
  end

  always_comb begin
    acc_sum  = '0;
    csum_sum = '0;
    for (int i = 0; i < N; i++) begin
      acc_sum  = acc_sum + ACC_W'(s1_prod[i]);
      csum_sum = csum_sum + CSUM_W'(s1_coef[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_shift <= '0;
      for (int i = 0; i < N; i++) begin
        s1_prod[i] <= '0;
        s1_coef[i] <= '0;
      end
    end else if (s1_advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode  <= bus.mode;
        s1_shift <= bus.shift_amt;
        for (int i = 0; i < N; i++) begin
          s1_prod[i] <= prod_in[i];
          s1_coef[i] <= bus.filter[(N-i)*COEF_W-1 -: COEF_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_acc   <= '0;
      s2_csum  <= '0;
      s2_mode  <= '0;
      s2_shift <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_acc   <= acc_sum;
        s2_csum  <= csum_sum;
        s2_mode  <= s1_mode;
        s2_shift <= s1_shift;
      end
    end
  end

  // A zero coefficient sum falls through to the raw accumulator instead of dividing.
  assign out_free = !out_valid_q || bus.out_ready;
  assign want_div = (s2_mode == MODE_DIV) && (s2_csum != '0);
  assign abs_acc  = s2_acc[ACC_W-1] ? ACC_W'(-s2_acc) : ACC_W'(s2_acc);
  assign csum_mag = s2_csum[CSUM_W-1] ? CSUM_W'(-s2_csum) : CSUM_W'(s2_csum);
  assign abs_csum = ACC_W'(csum_mag);
  assign div_r    = (s2_acc[ACC_W-1] ^ s2_csum[CSUM_W-1]) ? -$signed({1'b0, quotient})
                                                          :  $signed({1'b0, quotient});

  always_comb begin
    if (s2_mode == MODE_SHIFT) direct_r = (ACC_W+1)'(s2_acc >>> s2_shift);
    else                       direct_r = (ACC_W+1)'(s2_acc);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_start  = 1'b0;
    out_write  = 1'b0;
    s2_consume = 1'b0;
    norm_r     = direct_r;
    case (state)
      NS_IDLE: begin
        if (s2_valid && out_free) begin
          if (want_div) begin
            if (!div_busy) begin
              state_next = NS_DIV;
              cnt_next   = CNT_LOAD;
              div_start  = 1'b1;
            end
          end else begin
            out_write  = 1'b1;
            s2_consume = 1'b1;
          end
        end
      end
      NS_DIV: begin
        norm_r = div_r;
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (div_done) begin
          out_write  = 1'b1;
          s2_consume = 1'b1;
          state_next = NS_IDLE;
        end
      end
      default: state_next = NS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  conv_seq_divider #(.W(ACC_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (abs_acc),
    .divisor  (abs_csum),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Entering DIV requires a free output register, so the divide's final write never collides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else if (out_write) begin
      out_valid_q <= 1'b1;
      out_pixel_q <= clamp(norm_r);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pixel  = out_pixel_q;
  assign bus.norm_state = state;
  assign bus.div_cnt    = cnt;
endmodule

// File: tb/tb_conv_pipe_engine.sv
// Bench for conv_pipe_engine: directed cases, backpressure, mid-divide reset, random traffic.
module tb_conv_pipe_engine;
  import conv_pkg::*;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int K     = 3;
  localparam int N     = K * K;
  localparam int SHW   = sh_w(DW, CW, K);
  localparam int WIN_W = N * DW;
  localparam int FLT_W = N * CW;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int   pop_cyc_q[$];
  int   acc_list[$];
  int   rel_cyc;
  bit   rand_ready = 0;

  conv_pipe_engine_if #(.DATA_W(DW), .COEF_W(CW), .K(K)) bus();

  conv_pipe_engine #(.DATA_W(DW), .COEF_W(CW), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [WIN_W-1:0] fill_win(input int v, input int c);
    logic [WIN_W-1:0] w;
    for (int i = 0; i < N; i++) w[(N-i)*DW-1 -: DW] = (i == N/2) ? DW'(c) : DW'(v);
    return w;
  endfunction

  function automatic logic [FLT_W-1:0] fill_flt(input int v, input int c);
    logic [FLT_W-1:0] f;
    for (int i = 0; i < N; i++) f[(N-i)*CW-1 -: CW] = (i == N/2) ? CW'(c) : CW'(v);
    return f;
  endfunction

  // Reference: plain integer convolution, normalisation and clamp.
  function automatic int model(input logic [WIN_W-1:0] w, input logic [FLT_W-1:0] f,
                               input logic [1:0] m, input logic [SHW-1:0] s);
    int acc = 0, cs = 0, r;
    logic [DW-1:0] p;
    logic signed [CW-1:0] c;
    for (int i = 0; i < N; i++) begin
      p = w[(N-i)*DW-1 -: DW];
      c = f[(N-i)*CW-1 -: CW];
      acc += int'(p) * int'(c);
      cs  += int'(c);
    end
    case (m)
      2'd0:    r = (cs == 0) ? acc : acc / cs;
      2'd1:    r = acc >>> s;
      default: r = acc;
    endcase
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  task automatic send(input logic [WIN_W-1:0] w, input logic [FLT_W-1:0] f,
                      input logic [1:0] m, input logic [SHW-1:0] s, output int acc_cyc);
    int budget = 400;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.window    = w;
    bus.filter    = f;
    bus.mode      = m;
    bus.shift_amt = s;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
    #1;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      budget--;
    end
    chk("accept_wait", int'(bus.in_ready), 1);
    acc_cyc = cyc;
    exp_q.push_back(DW'(model(w, f, m, s)));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic drain();
    int budget = 600;
    rand_ready    = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    pop_cyc_q.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    while (pop_cyc_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("pop_wait", int'(pop_cyc_q.size() >= n), 1);
  endtask

  task automatic lat(input string name, input int a, input int req);
    wait_pops(1, 100);
    if (pop_cyc_q.size() > 0) chk(name, pop_cyc_q.pop_front() - a, req);
  endtask

  // Compare process: every output transfer against the model queue, and stall stability.
  logic [DW-1:0] held_pixel;
  bit stall_prev = 0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("stall_stable", int'(bus.out_pixel), int'(held_pixel));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none (cyc %0d)", bus.out_pixel, cyc);
        end else begin
          chk("out_pixel", int'(bus.out_pixel), int'(exp_q.pop_front()));
          pop_cyc_q.push_back(cyc);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_pixel = bus.out_pixel;
    end
  end

  logic [WIN_W-1:0] rw;
  logic [FLT_W-1:0] rf;
  logic [1:0]       rm;
  logic [SHW-1:0]   rs;
  int a, b, n;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.window    = '0;
    bus.filter    = '0;
    bus.mode      = '0;
    bus.shift_amt = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pixel", int'(bus.out_pixel), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_state", int'(bus.norm_state), int'(NS_IDLE));
    chk("rst_cnt", int'(bus.div_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    chk("pin_box", model(fill_win(100, 100), fill_flt(1, 1), 2'd0, '0), 100);
    chk("pin_sharpen", model(fill_win(50, 50), fill_flt(-1, 9), 2'd0, '0), 50);
    chk("pin_laplace", model(fill_win(0, 10), fill_flt(-1, 8), 2'd0, '0), 80);
    chk("pin_raw_sat", model(fill_win(255, 255), fill_flt(1, 1), 2'd2, '0), 255);
    chk("pin_raw_neg", model(fill_win(0, 200), fill_flt(0, -1), 2'd2, '0), 0);
    chk("pin_shift", model(fill_win(16, 16), fill_flt(2, 2), 2'd1, SHW'(4)), 18);

    send(fill_win(100, 100), fill_flt(1, 1), 2'd0, '0, a); idle();
    lat("lat_div_box", a, 24); drain();
    send(fill_win(50, 50), fill_flt(-1, 9), 2'd0, '0, a); idle();
    lat("lat_div_sharpen", a, 24); drain();
    send(fill_win(0, 10), fill_flt(-1, 8), 2'd0, '0, a); idle();
    lat("lat_div_csum0", a, 3); drain();
    send(fill_win(255, 255), fill_flt(1, 1), 2'd2, '0, a); idle();
    lat("lat_raw", a, 3); drain();
    send(fill_win(0, 200), fill_flt(0, -1), 2'd3, '0, a); idle();
    lat("lat_raw_neg", a, 3); drain();

    send(fill_win(16, 16), fill_flt(2, 2), 2'd1, SHW'(4), a);
    for (int k = 1; k < 5; k++) send(fill_win(16, 16 + k), fill_flt(2, 2), 2'd1, SHW'(4), b);
    idle();
    wait_pops(5, 60);
    if (pop_cyc_q.size() >= 5) begin
      chk("shift_first_lat", pop_cyc_q[0] - a, 3);
      chk("shift_burst_span", pop_cyc_q[4] - pop_cyc_q[0], 4);
    end
    drain();

    bus.out_ready = 1'b0;
    acc_list.delete();
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(fill_win(10 * (k + 1), 10 * (k + 1)), fill_flt(1, 1), 2'd2, '0, b);
          acc_list.push_back(b);
        end
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        bus.out_ready = 1'b1;
        rel_cyc = cyc;
      end
    join
    n = 0;
    foreach (acc_list[i]) if (acc_list[i] < rel_cyc) n++;
    chk("bp_accepts_before_release", n, 3);
    drain();

    send(fill_win(100, 100), fill_flt(1, 1), 2'd0, '0, a); idle();
    b = 100;
    while (!(bus.norm_state == NS_DIV && bus.div_cnt == SHW'(10)) && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    chk("reached_cnt10", int'(bus.div_cnt), 10);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_state", int'(bus.norm_state), int'(NS_IDLE));
    exp_q.delete();
    pop_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(fill_win(100, 100), fill_flt(1, 1), 2'd0, '0, a); idle();
    lat("lat_after_reset", a, 24); drain();

    rand_ready = 1;
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++) begin
        rw[(N-i)*DW-1 -: DW] = DW'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 0) rf[(N-i)*CW-1 -: CW] = CW'(int'($urandom_range(0, 9)) - 3);
        else                           rf[(N-i)*CW-1 -: CW] = CW'($urandom_range(0, 255));
      end
      b = int'($urandom_range(0, 9));
      if (b < 2)      rm = 2'd0;
      else if (b < 5) rm = 2'd1;
      else            rm = 2'($urandom_range(2, 3));
      rs = SHW'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) idle();
      send(rw, rf, rm, rs, b);
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
